// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot-time instruction memory loader
//
// Takes a framed byte stream {len_lo, len_hi, payload[4*len], csum} and
// writes the payload as little-endian 32-bit words into the IMEM write port.
// The core is held in reset until a complete, checksum-verified image is in.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   start                 pulse; begins a load from IDLE, DONE or ERR
//   rx_valid/rx_data      incoming stream byte
//   rx_ready              byte accepted when rx_valid & rx_ready at posedge
//   wr_en/wr_addr/wr_data IMEM word write, one-cycle strobe per word
//   busy                  high while a frame is being received
//   done                  image loaded and checksum good
//   error                 length overflow or checksum mismatch
//   cpu_hold              core reset hold; released only in DONE
module imem_loader #(
    parameter int unsigned         PC_WIDTH   = 32,
    parameter int unsigned         INST_WIDTH = 32,
    parameter int unsigned         IMEM_DEPTH = 1024,
    parameter logic [PC_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  rx_valid,
    input  logic [7:0]            rx_data,
    output logic                  rx_ready,
    output logic                  wr_en,
    output logic [PC_WIDTH-1:0]   wr_addr,
    output logic [INST_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic                  cpu_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic [1:0]  byte_idx_q;
    logic [15:0] word_idx_q;
    logic [15:0] word_cnt_q;
    logic [7:0]  len_lo_q;
    logic [23:0] asm_q;
    logic [7:0]  csum_q;

    logic        in_frame;
    logic        accept;
    logic [15:0] len_cnt;
    logic        oversize;
    logic        last_word;

    // Receiving states never backpressure, so ready is a pure state decode.
    assign in_frame = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_CSUM);
    assign accept   = rx_valid && in_frame;

    // Full length as it stands while the high byte is on the bus.
    assign len_cnt  = {rx_data, len_lo_q};
    // Compared in bytes, with headroom so 16-bit counts cannot wrap.
    assign oversize = ({16'd0, len_cnt, 2'b00} > 34'(IMEM_DEPTH));
    // word_cnt is at most IMEM_DEPTH/4 in DATA, so the +1 cannot overflow.
    assign last_word = ((word_idx_q + 16'd1) == word_cnt_q);

    assign rx_ready = in_frame;
    assign busy     = in_frame;
    assign done     = (state_q == S_DONE);
    assign error    = (state_q == S_ERR);
    assign cpu_hold = (state_q != S_DONE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (accept && (byte_idx_q == 2'd1)) begin
                    if (oversize) begin
                        state_d = S_ERR;
                    end else if (len_cnt == 16'd0) begin
                        state_d = S_CSUM;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && (byte_idx_q == 2'd3) && last_word) begin
                    state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (accept) begin
                    state_d = (rx_data == csum_q) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_idx_q <= 2'd0;
            word_idx_q <= 16'd0;
            word_cnt_q <= 16'd0;
            len_lo_q   <= 8'd0;
            asm_q      <= 24'd0;
            csum_q     <= 8'd0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        byte_idx_q <= 2'd0;
                        word_idx_q <= 16'd0;
                        csum_q     <= 8'd0;
                    end
                end
                S_LEN: begin
                    if (accept) begin
                        if (byte_idx_q == 2'd0) begin
                            len_lo_q   <= rx_data;
                            byte_idx_q <= 2'd1;
                        end else begin
                            word_cnt_q <= len_cnt;
                            byte_idx_q <= 2'd0;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        csum_q     <= csum_q ^ rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: asm_q[7:0]   <= rx_data;
                            2'd1: asm_q[15:8]  <= rx_data;
                            2'd2: asm_q[23:16] <= rx_data;
                            default: begin
                                // Fourth byte completes the word; it goes
                                // straight into wr_data, not through asm_q.
                                wr_en      <= 1'b1;
                                wr_data    <= INST_WIDTH'({rx_data, asm_q});
                                wr_addr    <= BASE_ADDR + PC_WIDTH'({word_idx_q, 2'b00});
                                word_idx_q <= word_idx_q + 16'd1;
                            end
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
